uart_rx_frame: RTL and testbench

- UART receive front-end: oversamples the serial line RX_IN, deserialises one frame and presents the byte as P_DATA with a one-cycle DATA_VLD strobe.
- Sits directly upstream of the system controller; P_DATA/DATA_VLD drive its RX_P_Data/RX_D_VLD inputs.
- Runs in the RX clock domain. CLK = Prescale × baud rate.
- Frame format: start(0), 8 data bits LSB first, optional parity bit, stop(1).

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_frame_if.sv | 13 +
 rtl/uart_rx_sampler.sv | 56 +++++
 rtl/uart_rx_frame.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM state encodings,
// legal oversampling ratios and parity-type selectors.
package uart_pkg;

  // FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Legal oversampling ratios
  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  // Parity type selectors
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic int unsigned presc_norm(input int unsigned p);
    if (p == PRESC_16) return PRESC_16;
    if (p == PRESC_32) return PRESC_32;
    return PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Received-byte bus from the UART receiver to the system controller:
// byte, valid strobe and the two error strobes.
interface uart_rx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VLD;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport master (output P_DATA, output DATA_VLD, output PAR_ERR, output STP_ERR);
  modport slave  (input  P_DATA, input  DATA_VLD, input  PAR_ERR, input  STP_ERR);
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: counts oversampling edges within
// a bit, takes three samples around the bit centre, majority-votes them and
// flags the last edge of the bit period.
module uart_rx_sampler #(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] presc,
  input  logic               run,
  output logic               bit_end,
  output logic               bit_val
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]         samp_q, samp_d;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] last;

  // Sample points and bit-end position derived from the latched ratio
  always_comb begin
    half    = presc >> 1;
    last    = presc - PRESC_W'(1);
    bit_end = run && (edge_cnt_q == last);
    bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  end

  // Edge counter wraps each bit period; held at 0 while no frame is active
  always_comb begin
    edge_cnt_d = '0;
    if (run && !bit_end) edge_cnt_d = edge_cnt_q + PRESC_W'(1);
  end

  // Capture three samples centred on the bit
  always_comb begin
    samp_d = samp_q;
    if (run) begin
      if (edge_cnt_q == half - PRESC_W'(1)) samp_d[0] = rx_in;
      if (edge_cnt_q == half)               samp_d[1] = rx_in;
      if (edge_cnt_q == half + PRESC_W'(1)) samp_d[2] = rx_in;
    end
  end

  // Counter and sample registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      samp_q     <= '1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive front-end: detects a start bit on RX_IN, deserialises one
// LSB-first frame with optional parity, checks parity and stop bit, and
// presents the byte with a one-cycle DATA_VLD strobe.
// Build option: define UART_RX_SYNC_EN to pass RX_IN through a 2-flop
// synchroniser (adds 2 cycles of latency).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  uart_rx_frame_if.master    rx_if
);

  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Shift the raw line into the synchroniser chain
  always_comb sync_d = {sync_q[0], RX_IN};

  // Synchroniser flops, idle-high after reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '1;
    else      sync_q <= sync_d;
  end

  // Line seen by the FSM is the synchronised copy
  always_comb rx_s = sync_q[1];
`else
  // Line is already synchronous to CLK
  always_comb rx_s = RX_IN;
`endif

  logic [2:0]            state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  frame_bad_q, frame_bad_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  run;
  logic                  bit_end;
  logic                  bit_val;

  // Bit timing only runs while a frame is being received
  always_comb run = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .CLK     (CLK),
    .RST     (RST),
    .rx_in   (rx_s),
    .presc   (presc_q),
    .run     (run),
    .bit_end (bit_end),
    .bit_val (bit_val)
  );

  // Frame FSM: deserialise, check parity/stop, publish the byte.
  // The byte and DATA_VLD are registered on the STOP->DONE edge so that
  // they are visible exactly during the single DONE cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    p_data_d    = p_data_q;
    frame_bad_d = frame_bad_q;
    presc_d     = presc_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    data_vld_d  = 1'b0;
    par_err_d   = 1'b0;
    stp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          presc_d   = PRESC_W'(presc_norm(32'(Prescale)));
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = bit_val ? ST_IDLE : ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          if (bit_val != (^shift_q ^ par_typ_q)) begin
            par_err_d   = 1'b1;
            frame_bad_d = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!bit_val) begin
            stp_err_d   = 1'b1;
            frame_bad_d = 1'b1;
          end else if (!frame_bad_q) begin
            data_vld_d = 1'b1;
            p_data_d   = shift_q;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_bad_d = 1'b0;
        if (!rx_s) begin
          state_d   = ST_START;
          presc_d   = PRESC_W'(presc_norm(32'(Prescale)));
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, datapath and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      p_data_q    <= '0;
      data_vld_q  <= 1'b0;
      par_err_q   <= 1'b0;
      stp_err_q   <= 1'b0;
      frame_bad_q <= 1'b0;
      presc_q     <= PRESC_W'(PRESC_8);
      par_en_q    <= 1'b0;
      par_typ_q   <= PAR_EVEN;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      p_data_q    <= p_data_d;
      data_vld_q  <= data_vld_d;
      par_err_q   <= par_err_d;
      stp_err_q   <= stp_err_d;
      frame_bad_q <= frame_bad_d;
      presc_q     <= presc_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
    end
  end

  // Drive the received-byte bus
  always_comb begin
    rx_if.P_DATA   = p_data_q;
    rx_if.DATA_VLD = data_vld_q;
    rx_if.PAR_ERR  = par_err_q;
    rx_if.STP_ERR  = stp_err_q;
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and random frames, expected pulses
// queued at stimulus time and compared by an independent monitor.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;
  localparam int K_VLD = 0;
  localparam int K_PAR = 1;
  localparam int K_STP = 2;

`ifdef UART_RX_SYNC_EN
  localparam int unsigned LAT_ADD = 2;
`else
  localparam int unsigned LAT_ADD = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] Prescale = 6'd8;

  uart_rx_frame_if #(.DATA_WIDTH(DW)) rx_if ();

  uart_rx_frame #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .Prescale (Prescale),
    .rx_if    (rx_if)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [7:0]  pdata;
    int unsigned at;
    bit          timed;
  } ev_t;

  ev_t         sb[$];
  logic [7:0]  model_pdata = 8'h00;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    int  kind;
    ev_t e;
    if (RST && (rx_if.DATA_VLD || rx_if.PAR_ERR || rx_if.STP_ERR)) begin
      check("pulse_exclusive",
            32'(rx_if.DATA_VLD) + 32'(rx_if.PAR_ERR) + 32'(rx_if.STP_ERR), 32'd1);
      kind = rx_if.DATA_VLD ? K_VLD : (rx_if.PAR_ERR ? K_PAR : K_STP);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: kind %0d seen, none expected (cycle %0d)", kind, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(kind), 32'(e.kind));
        check("p_data", 32'(rx_if.P_DATA), 32'(e.pdata));
        if (e.timed) check("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle(input int unsigned n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive one frame one bit-period per P cycles; expectations derived from
  // the frame contents alone. abort_at != 0 stops driving early, no pushes.
  task automatic send_frame(input logic [7:0] data, input logic [PW-1:0] presc,
                            input bit pe, input bit pt, input bit bad_par,
                            input bit bad_stop, input bit glitch, input bit scramble,
                            input bit timed, input int unsigned abort_at);
    int unsigned p;
    int unsigned start;
    logic        bits[$];
    logic        par_bit;
    bit          par_err;
    bit          vld;
    ev_t         e;
    p = 8;
    if (presc == 6'd16) p = 16;
    if (presc == 6'd32) p = 32;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    par_bit = (^data) ^ pt;
    if (pe) bits.push_back(par_bit ^ bad_par);
    bits.push_back(!bad_stop);
    par_err = pe && bad_par;
    vld     = !par_err && !bad_stop;

    Prescale = presc;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    start    = cyc + 1;

    if (abort_at == 0) begin
      if (par_err) begin
        e = '{kind: K_PAR, pdata: model_pdata, at: start + 10 * p + LAT_ADD, timed: timed};
        sb.push_back(e);
      end
      if (bad_stop) begin
        e = '{kind: K_STP, pdata: model_pdata, at: start + (10 + 32'(pe)) * p + LAT_ADD, timed: timed};
        sb.push_back(e);
      end
      if (vld) begin
        model_pdata = data;
        e = '{kind: K_VLD, pdata: data, at: start + (10 + 32'(pe)) * p + LAT_ADD, timed: timed};
        sb.push_back(e);
      end
    end

    for (int i = 0; i < bits.size(); i++) begin
      for (int unsigned j = 0; j < p; j++) begin
        if (abort_at != 0 && (32'(i) * p + j) >= abort_at) return;
        RX_IN = bits[i];
        if (glitch && i >= 1 && i <= 8 && j == p / 2 + 1) RX_IN = ~bits[i];
        if (scramble && i >= 1 && j == 0) begin
          Prescale = PW'($urandom);
          PAR_EN   = ($urandom_range(0, 1) == 1);
          PAR_TYP  = ($urandom_range(0, 1) == 1);
        end
        @(posedge CLK);
        #1;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] pr;
    logic [PW-1:0] illegal_p[4];
    illegal_p[0] = 6'd0;
    illegal_p[1] = 6'd12;
    illegal_p[2] = 6'd20;
    illegal_p[3] = 6'd63;

    // Reset state
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_p_data", 32'(rx_if.P_DATA), 32'h0);
    check("rst_data_vld", 32'(rx_if.DATA_VLD), 32'h0);
    check("rst_par_err", 32'(rx_if.PAR_ERR), 32'h0);
    check("rst_stp_err", 32'(rx_if.STP_ERR), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b1;
    idle(5);

    // Directed cases
    send_frame(8'hA5, 6'd8, 0, 0, 0, 0, 0, 0, 1, 0);   idle(10);
    send_frame(8'h3C, 6'd16, 1, 0, 0, 0, 0, 0, 1, 0);  idle(10);
    send_frame(8'h3C, 6'd16, 1, 0, 1, 0, 0, 0, 1, 0);  idle(10);
    send_frame(8'h81, 6'd32, 0, 0, 0, 1, 0, 0, 1, 0);  idle(10);

    // Start-bit glitch: three low cycles only
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    idle(20);
    check("glitch_start_idle", 32'(dut.state_q), 32'(ST_IDLE));
    send_frame(8'h55, 6'd8, 0, 0, 0, 0, 0, 0, 1, 0);   idle(10);

    // Mid-sample glitches on every data bit
    send_frame(8'hF0, 6'd8, 0, 0, 0, 0, 1, 0, 1, 0);   idle(10);

    // Parity with both error kinds in one frame, odd parity
    send_frame(8'h6E, 6'd16, 1, 1, 1, 1, 0, 0, 1, 0);  idle(10);

    // Random frames with configuration scrambled mid-frame
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0: pr = 6'd8;
        1: pr = 6'd16;
        2: pr = 6'd32;
        default: pr = illegal_p[$urandom_range(0, 3)];
      endcase
      send_frame(8'($urandom), pr, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), 1, 0);
      idle($urandom_range(1, 8));
    end

    // Back-to-back frames, then reset during a third
    idle(10);
    send_frame(8'h12, 6'd16, 0, 0, 0, 0, 0, 0, 1, 0);
    send_frame(8'h34, 6'd16, 0, 0, 0, 0, 0, 0, 0, 0);
    send_frame(8'h56, 6'd16, 0, 0, 0, 0, 0, 0, 0, 4 * 16);
    check("b2b_drained", 32'(sb.size()), 32'd0);
    RST = 1'b0;
    #1;
    check("midrst_p_data", 32'(rx_if.P_DATA), 32'h0);
    check("midrst_data_vld", 32'(rx_if.DATA_VLD), 32'h0);
    check("midrst_par_err", 32'(rx_if.PAR_ERR), 32'h0);
    check("midrst_stp_err", 32'(rx_if.STP_ERR), 32'h0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    model_pdata = 8'h00;
    sb.delete();
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    idle(5);
    send_frame(8'hC3, 6'd8, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(40);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("p_data_final", 32'(rx_if.P_DATA), 32'(model_pdata));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
